// File: rtl/ahb_pkg.sv
// AHB-Lite encodings, FSM state codes and the byte-lane decoder shared by
// the SRAM slave and its bench.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    localparam logic [2:0] HSIZE_BYTE  = 3'd0;
    localparam logic [2:0] HSIZE_HALF  = 3'd1;
    localparam logic [2:0] HSIZE_WORD  = 3'd2;
    localparam logic [2:0] HSIZE_DWORD = 3'd3;

    // Data-phase FSM; plain encoded constants so older code can compare directly.
    typedef logic [2:0] fsm_state_t;
    localparam fsm_state_t ST_IDLE  = 3'd0;
    localparam fsm_state_t ST_WDATA = 3'd1;
    localparam fsm_state_t ST_RDATA = 3'd2;
    localparam fsm_state_t ST_ERR1  = 3'd3;
    localparam fsm_state_t ST_ERR2  = 3'd4;

    // Byte lanes touched by a transfer. Only the low DATA_W/8 bits are
    // meaningful; alignment is checked separately, so this just shifts the
    // size mask to the lane selected by the low address bits.
    function automatic logic [7:0] be_decode(input logic [2:0] hsize,
                                             input logic [2:0] addr_lsb,
                                             input int         data_w);
        logic [15:0] mask;
        logic [2:0]  lsb;
        lsb = (data_w == 64) ? addr_lsb : {1'b0, addr_lsb[1:0]};
        case (hsize)
            HSIZE_BYTE: mask = 16'h0001;
            HSIZE_HALF: mask = 16'h0003;
            HSIZE_WORD: mask = 16'h000F;
            default:    mask = 16'h00FF;
        endcase
        mask = mask << lsb;
        return mask[7:0];
    endfunction

endpackage

// File: rtl/spram_generic_wbe.sv
// Generic single-port SRAM: one-cycle synchronous read, byte-masked write.
// Read data holds its value on cycles without a read.
module spram_generic_wbe #(
    parameter int ADDR_BITS   = 10,
    parameter int ADDR_AMOUNT = 1024,
    parameter int DATA_BITS   = 32
) (
    input  logic                   clk,
    input  logic                   en,
    input  logic                   we,
    input  logic [DATA_BITS/8-1:0] be,
    input  logic [ADDR_BITS-1:0]   addr,
    input  logic [DATA_BITS-1:0]   wdata,
    output logic [DATA_BITS-1:0]   rdata
);

    logic [DATA_BITS-1:0] mem [ADDR_AMOUNT];

    // Byte-lane write and registered read sharing the single port.
    always_ff @(posedge clk) begin
        if (en && we) begin
            for (int i = 0; i < DATA_BITS/8; i++) begin
                if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
        if (en && !we) rdata <= mem[addr];
    end

endmodule

// File: rtl/ahb_sram_wbuf.sv
// AHB-Lite slave for a byte-enabled single-port SRAM with a one-entry posted
// write buffer, read-after-write forwarding, optional read wait states and
// an ERROR response for oversized or misaligned transfers.
module ahb_sram_wbuf
    import ahb_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int MEM_DEPTH = 1024,
    parameter int ADDR_W    = 10,
    parameter int RD_WAIT   = 0
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 hsel,
    input  logic [ADDR_W+$clog2(DATA_W/8)-1:0]   haddr,
    input  logic [1:0]                           htrans,
    input  logic [2:0]                           hsize,
    input  logic [2:0]                           hburst,
    input  logic [3:0]                           hprot,
    input  logic                                 hwrite,
    input  logic [DATA_W-1:0]                    hwdata,
    input  logic                                 hready,
    output logic                                 hreadyout,
    output logic                                 hresp,
    output logic [DATA_W-1:0]                    hrdata
);

    localparam int BE_W  = DATA_W / 8;
    localparam int LSB_W = $clog2(BE_W);

    // Oversized for the bus, or not naturally aligned for its size.
    function automatic logic size_err(input logic [2:0] sz, input logic [2:0] lsb);
        logic [2:0] align_mask;
        case (sz)
            HSIZE_BYTE: align_mask = 3'b000;
            HSIZE_HALF: align_mask = 3'b001;
            HSIZE_WORD: align_mask = 3'b011;
            default:    align_mask = 3'b111;
        endcase
        if (int'(sz) > LSB_W) return 1'b1;
        return (lsb & align_mask) != 3'b000;
    endfunction

    // Lanes flagged in be (when hit) take ovr, the rest keep base.
    function automatic logic [DATA_W-1:0] byte_merge(input logic [DATA_W-1:0] base,
                                                     input logic [DATA_W-1:0] ovr,
                                                     input logic [BE_W-1:0]   be,
                                                     input logic              hit);
        logic [DATA_W-1:0] res;
        res = base;
        for (int i = 0; i < BE_W; i++) begin
            if (hit && be[i]) res[8*i +: 8] = ovr[8*i +: 8];
        end
        return res;
    endfunction

    fsm_state_t        state, state_nxt;
    logic              acc, err, rd_claim, rd_issue, stall, last;
    logic              drain, wb_load, fwd_hit;
    logic [2:0]        addr_lsb;
    logic [7:0]        be_full;
    logic [BE_W-1:0]   be_dec;
    logic [ADDR_W-1:0] haddr_word;
    logic [ADDR_W-1:0] ap_addr_p0, wb_addr, sram_addr;
    logic [BE_W-1:0]   ap_be_p0, wb_be;
    logic [DATA_W-1:0] wb_data, rd_hold, rd_src, rd_merged, sram_dout;
    logic              wb_vld, rd_first;
    logic [1:0]        wcnt;
    logic              unused_bus;

    assign unused_bus = ^{hburst, hprot, htrans[0], be_full};

    // Address-phase decode: lanes, word address and error check.
    always_comb begin
        addr_lsb = 3'b000;
        addr_lsb[LSB_W-1:0] = haddr[LSB_W-1:0];
        be_full    = be_decode(hsize, addr_lsb, DATA_W);
        be_dec     = be_full[BE_W-1:0];
        haddr_word = haddr[ADDR_W+LSB_W-1:LSB_W];
        err        = size_err(hsize, addr_lsb);
    end

    // rd_claim ignores hready so the stall decision never loops through the
    // interconnect's hready mux back into hreadyout.
    always_comb begin
        acc      = hsel & hready & htrans[1];
        rd_claim = hsel & htrans[1] & ~hwrite & ~err;
        stall    = (state == ST_WDATA) & wb_vld & rd_claim;
        case (state)
            ST_WDATA: last = ~stall;
            ST_RDATA: last = (wcnt == 2'd0);
            ST_ERR1:  last = 1'b0;
            default:  last = 1'b1;
        endcase
        rd_issue  = rd_claim & hready & last;
        drain     = wb_vld & ~rd_issue;
        wb_load   = (state == ST_WDATA) & ~stall;
        hreadyout = last;
        hresp     = (state == ST_ERR1 || state == ST_ERR2) ? HRESP_ERROR : HRESP_OKAY;
    end

    // Next data-phase state; a new transfer is only taken on a closing cycle.
    always_comb begin
        state_nxt = state;
        if (last) begin
            if (!acc)        state_nxt = ST_IDLE;
            else if (err)    state_nxt = ST_ERR1;
            else if (hwrite) state_nxt = ST_WDATA;
            else             state_nxt = ST_RDATA;
        end else if (state == ST_ERR1) begin
            state_nxt = ST_ERR2;
        end
    end

    // Read data path: newer buffered bytes always win over SRAM bytes.
    always_comb begin
        fwd_hit   = wb_vld & (wb_addr == ap_addr_p0);
        rd_src    = rd_first ? sram_dout : rd_hold;
        rd_merged = byte_merge(rd_src, wb_data, wb_be, fwd_hit);
        hrdata    = (state == ST_RDATA) ? rd_merged : '0;
        sram_addr = rd_issue ? haddr_word : wb_addr;
    end

    // Control state: FSM, buffer valid, wait counter, first-read-cycle flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            wb_vld   <= 1'b0;
            wcnt     <= 2'd0;
            rd_first <= 1'b0;
        end else begin
            state    <= state_nxt;
            rd_first <= rd_issue;
            if (wb_load)    wb_vld <= 1'b1;
            else if (drain) wb_vld <= 1'b0;
            if (rd_issue)
                wcnt <= 2'(RD_WAIT);
            else if (state == ST_RDATA && wcnt != 2'd0)
                wcnt <= wcnt - 2'd1;
        end
    end

    // Datapath registers. rd_hold folds in the buffer each wait cycle so a
    // drain during the wait cannot lose bytes the SRAM read predates.
    always_ff @(posedge clk) begin
        if (acc) begin
            ap_addr_p0 <= haddr_word;
            ap_be_p0   <= be_dec;
        end
        if (wb_load) begin
            wb_addr <= ap_addr_p0;
            wb_be   <= ap_be_p0;
            wb_data <= hwdata;
        end
        if (state == ST_RDATA && !last) rd_hold <= rd_merged;
    end

    spram_generic_wbe #(
        .ADDR_BITS   (ADDR_W),
        .ADDR_AMOUNT (MEM_DEPTH),
        .DATA_BITS   (DATA_W)
    ) u_sram (
        .clk   (clk),
        .en    (rd_issue | drain),
        .we    (drain),
        .be    (wb_be),
        .addr  (sram_addr),
        .wdata (wb_data),
        .rdata (sram_dout)
    );

endmodule

// File: tb/tb_ahb_sram_wbuf.sv
// Directed bench: one zero-wait-state slave and one with two read wait states
// share the address/data bus and are told apart by their hsel.
module tb_ahb_sram_wbuf;
    import ahb_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        hsel0, hsel1, hwrite;
    logic [11:0] haddr;
    logic [1:0]  htrans;
    logic [2:0]  hsize, hburst;
    logic [3:0]  hprot;
    logic [31:0] hwdata;
    logic        hro0, hro1, hresp0, hresp1;
    logic [31:0] hrdata0, hrdata1;
    logic [31:0] lowcnt;
    int          n_chk = 0;
    int          n_pass = 0;

    always #5 clk = ~clk;

    ahb_sram_wbuf #(.DATA_W(32), .MEM_DEPTH(1024), .ADDR_W(10), .RD_WAIT(0)) dut (
        .clk(clk), .rst(rst), .hsel(hsel0), .haddr(haddr), .htrans(htrans),
        .hsize(hsize), .hburst(hburst), .hprot(hprot), .hwrite(hwrite),
        .hwdata(hwdata), .hready(hro0), .hreadyout(hro0), .hresp(hresp0),
        .hrdata(hrdata0)
    );

    ahb_sram_wbuf #(.DATA_W(32), .MEM_DEPTH(1024), .ADDR_W(10), .RD_WAIT(2)) dut_w (
        .clk(clk), .rst(rst), .hsel(hsel1), .haddr(haddr), .htrans(htrans),
        .hsize(hsize), .hburst(hburst), .hprot(hprot), .hwrite(hwrite),
        .hwdata(hwdata), .hready(hro1), .hreadyout(hro1), .hresp(hresp1),
        .hrdata(hrdata1)
    );

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic ap(input logic s0, input logic s1, input logic wr,
                      input logic [11:0] a, input logic [2:0] sz);
        hsel0  = s0;
        hsel1  = s1;
        hwrite = wr;
        haddr  = a;
        hsize  = sz;
        htrans = HTRANS_NONSEQ;
    endtask

    task automatic ap_idle();
        hsel0  = 1'b0;
        hsel1  = 1'b0;
        hwrite = 1'b0;
        htrans = HTRANS_IDLE;
    endtask

    // Word write followed by one idle cycle so the buffer drains.
    task automatic wr_word(input logic s0, input logic s1, input logic [11:0] a,
                           input logic [31:0] d);
        ap(s0, s1, 1'b1, a, HSIZE_WORD);
        nxt();
        hwdata = d;
        ap_idle();
        nxt();
        nxt();
    endtask

    // Word read on the zero-wait slave, data checked in its data phase.
    task automatic rd_chk(input string tag, input logic [11:0] a, input logic [31:0] exp);
        ap(1'b1, 1'b0, 1'b0, a, HSIZE_WORD);
        nxt();
        ap_idle();
        smp();
        chk1({tag, "_ready"}, hro0, 1'b1);
        chk32(tag, hrdata0, exp);
        nxt();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        ap_idle();
        haddr  = '0;
        hsize  = HSIZE_WORD;
        hwdata = '0;
        hburst = '0;
        hprot  = '0;
        lowcnt = '0;
        #2;
        chk1("rst_hreadyout", hro0, 1'b1);
        chk1("rst_hresp", hresp0, 1'b0);
        chk32("rst_hrdata", hrdata0, 32'h0);
        chk1("rst_w_hreadyout", hro1, 1'b1);
        #10 rst = 1'b0;
        nxt();

        wr_word(1'b1, 1'b0, 12'h000, 32'hDEADBEEF);
        wr_word(1'b1, 1'b0, 12'h008, 32'h55AA55AA);
        wr_word(1'b1, 1'b0, 12'h060, 32'h12345678);
        wr_word(1'b0, 1'b1, 12'h020, 32'h89ABCDEF);

        // Byte write into lane 3, idle, read back the whole word.
        ap(1'b1, 1'b0, 1'b1, 12'h003, HSIZE_BYTE);
        nxt();
        hwdata = 32'hA5000000;
        ap_idle();
        smp();
        chk1("t1_wr_zero_wait", hro0, 1'b1);
        nxt();
        smp();
        chk32("t1_idle_hrdata", hrdata0, 32'h0);
        nxt();
        rd_chk("t1_read", 12'h000, 32'hA5ADBEEF);

        // Write immediately followed by a read of the same word: forwarded.
        ap(1'b1, 1'b0, 1'b1, 12'h010, HSIZE_WORD);
        nxt();
        hwdata = 32'h11223344;
        ap(1'b1, 1'b0, 1'b0, 12'h010, HSIZE_WORD);
        smp();
        chk1("t2_wr_ready", hro0, 1'b1);
        nxt();
        ap_idle();
        smp();
        chk32("t2_fwd_data", hrdata0, 32'h11223344);
        chk1("t2_fwd_ready", hro0, 1'b1);
        nxt();
        nxt();

        // W 0x40, W 0x44, R 0x10, W 0x48, R 0x40: only W 0x44 stalls once.
        ap(1'b1, 1'b0, 1'b1, 12'h040, HSIZE_WORD);
        nxt();
        hwdata = 32'hCAFEF00D;
        ap(1'b1, 1'b0, 1'b1, 12'h044, HSIZE_WORD);
        smp();
        if (!hro0) lowcnt = lowcnt + 32'd1;
        chk1("t3_w1_ready", hro0, 1'b1);
        nxt();
        hwdata = 32'h0BADC0DE;
        ap(1'b1, 1'b0, 1'b0, 12'h010, HSIZE_WORD);
        smp();
        if (!hro0) lowcnt = lowcnt + 32'd1;
        chk1("t3_w2_stall", hro0, 1'b0);
        nxt();
        smp();
        if (!hro0) lowcnt = lowcnt + 32'd1;
        chk1("t3_w2_done", hro0, 1'b1);
        nxt();
        ap(1'b1, 1'b0, 1'b1, 12'h048, HSIZE_WORD);
        smp();
        if (!hro0) lowcnt = lowcnt + 32'd1;
        chk32("t3_r1_data", hrdata0, 32'h11223344);
        nxt();
        hwdata = 32'h13579BDF;
        ap(1'b1, 1'b0, 1'b0, 12'h040, HSIZE_WORD);
        smp();
        if (!hro0) lowcnt = lowcnt + 32'd1;
        nxt();
        ap_idle();
        smp();
        if (!hro0) lowcnt = lowcnt + 32'd1;
        chk32("t3_r2_data", hrdata0, 32'hCAFEF00D);
        nxt();
        chk32("t3_low_cycles", lowcnt, 32'd1);
        rd_chk("t3_mem44", 12'h044, 32'h0BADC0DE);
        rd_chk("t3_mem48", 12'h048, 32'h13579BDF);

        // Doubleword on a 32-bit bus: two-cycle ERROR, memory untouched.
        ap(1'b1, 1'b0, 1'b1, 12'h008, HSIZE_DWORD);
        nxt();
        ap_idle();
        smp();
        chk1("t4_err1_ready", hro0, 1'b0);
        chk1("t4_err1_resp", hresp0, 1'b1);
        nxt();
        hwdata = 32'hFFFFFFFF;
        smp();
        chk1("t4_err2_ready", hro0, 1'b1);
        chk1("t4_err2_resp", hresp0, 1'b1);
        nxt();
        smp();
        chk1("t4_idle_resp", hresp0, 1'b0);
        nxt();
        rd_chk("t4_mem_unchanged", 12'h008, 32'h55AA55AA);
        ap(1'b1, 1'b0, 1'b0, 12'h001, HSIZE_HALF);
        nxt();
        ap_idle();
        smp();
        chk1("t4_misalign_resp", hresp0, 1'b1);
        chk1("t4_misalign_ready", hro0, 1'b0);
        nxt();
        nxt();

        // Two read wait states on the second slave.
        ap(1'b0, 1'b1, 1'b0, 12'h020, HSIZE_WORD);
        nxt();
        ap_idle();
        smp();
        chk1("t5_wait1", hro1, 1'b0);
        nxt();
        smp();
        chk1("t5_wait2", hro1, 1'b0);
        nxt();
        smp();
        chk1("t5_ready", hro1, 1'b1);
        chk32("t5_data", hrdata1, 32'h89ABCDEF);
        nxt();
        // Forwarded read whose buffer drains during the wait states.
        ap(1'b0, 1'b1, 1'b1, 12'h024, HSIZE_WORD);
        nxt();
        hwdata = 32'h0F1E2D3C;
        ap(1'b0, 1'b1, 1'b0, 12'h024, HSIZE_WORD);
        nxt();
        ap_idle();
        nxt();
        nxt();
        smp();
        chk1("t5_fwd_ready", hro1, 1'b1);
        chk32("t5_fwd_data", hrdata1, 32'h0F1E2D3C);
        nxt();

        // Reset while a buffered write is pending: it must never reach SRAM.
        ap(1'b1, 1'b0, 1'b1, 12'h060, HSIZE_WORD);
        nxt();
        hwdata = 32'hAAAAAAAA;
        ap(1'b1, 1'b0, 1'b1, 12'h064, HSIZE_WORD);
        nxt();
        hwdata = 32'hBBBBBBBB;
        ap_idle();
        #2 rst = 1'b1;
        #1;
        chk1("t6_rst_ready", hro0, 1'b1);
        chk1("t6_rst_resp", hresp0, 1'b0);
        chk32("t6_rst_hrdata", hrdata0, 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        rd_chk("t6_not_committed", 12'h060, 32'h12345678);

        // Reset during a read wait state releases hreadyout at once.
        ap(1'b0, 1'b1, 1'b0, 12'h020, HSIZE_WORD);
        nxt();
        ap_idle();
        smp();
        chk1("t6_pre_wait", hro1, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk1("t6_wait_rst_ready", hro1, 1'b1);
        chk32("t6_wait_rst_hrdata", hrdata1, 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        nxt();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
